// File: rtl/link_seq_ctrl.sv
// Link sequencing controller: unloads received packets byte-by-byte over SPI
// frames (RX) or shifts one SPI byte out bit-by-bit (TX), with sticky overflow/timeout flags.
module link_seq_ctrl #(
    parameter int unsigned BYTES   = 8,
    parameter int unsigned BITS    = 8,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       PRESETn,
    input  logic       rx_mode,
    input  logic       pkt_rec,
    input  logic       cs,
    input  logic       bit_tick,
    input  logic       ovf_clr,
    output logic       pkt_ld,
    output logic       spi_ld,
    output logic       pkt_en,
    output logic       tx_ld,
    output logic       tx_en,
    output logic       done,
    output logic       busy,
    output logic [3:0] byte_cnt,
    output logic       ovf,
    output logic       tmo
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO_W = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_ARM   = 3'd1,
        RX_XFER  = 3'd2,
        TX_ARM   = 3'd3,
        TX_SHIFT = 3'd4,
        TX_END   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               cs_meta_q, cs_s_q, cs_prev_q;
    logic               pkt_rec_q;
    logic [TMO_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               pkt_ld_q, pkt_ld_d;
    logic               spi_ld_q, spi_ld_d;
    logic               pkt_en_q, pkt_en_d;
    logic               tx_ld_q, tx_ld_d;
    logic               tx_en_q, tx_en_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic               tmo_q, tmo_d;

    logic               cs_fall, cs_rise, cs_edge, pkt_rise;
    logic [CNT_W-1:0]   byte_inc, bit_inc;

    assign cs_fall  = cs_prev_q & ~cs_s_q;
    assign cs_rise  = ~cs_prev_q & cs_s_q;
    assign cs_edge  = cs_fall | cs_rise;
    assign pkt_rise = pkt_rec & ~pkt_rec_q;
    assign byte_inc = byte_cnt_q + CNT_W'(1);
    assign bit_inc  = bit_cnt_q + CNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        pkt_ld_d   = 1'b0;
        spi_ld_d   = 1'b0;
        pkt_en_d   = 1'b0;
        tx_ld_d    = 1'b0;
        tx_en_d    = 1'b0;
        done_d     = 1'b0;
        ovf_d      = ovf_clr ? 1'b0 : ovf_q;
        tmo_d      = ovf_clr ? 1'b0 : tmo_q;

        // A packet arriving mid-operation is only flagged; set beats clear
        if (pkt_rise && (state_q != IDLE)) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rx_mode) begin
                    if (pkt_rise) begin
                        pkt_ld_d   = 1'b1;
                        spi_ld_d   = 1'b1;
                        byte_cnt_d = '0;
                        idle_cnt_d = '0;
                        state_d    = RX_ARM;
                    end
                end else if (cs_fall) begin
                    state_d = TX_ARM;
                end
            end
            RX_ARM, RX_XFER: begin
                if (cs_edge) begin
                    idle_cnt_d = '0;
                    if (state_q == RX_ARM) begin
                        if (cs_fall) begin
                            state_d = RX_XFER;
                        end
                    end else if (cs_rise) begin
                        pkt_en_d   = 1'b1;
                        byte_cnt_d = byte_inc;
                        if (byte_inc == CNT_W'(BYTES)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = RX_ARM;
                        end
                    end
                end else if (idle_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + TMO_W'(1);
                end
            end
            TX_ARM: begin
                if (cs_rise) begin
                    tx_ld_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (bit_tick) begin
                    tx_en_d   = 1'b1;
                    bit_cnt_d = bit_inc;
                    if (bit_inc == CNT_W'(BITS)) begin
                        state_d = TX_END;
                    end
                end
            end
            TX_END: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, synchronizer and output registers
    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            cs_meta_q  <= 1'b1;
            cs_s_q     <= 1'b1;
            cs_prev_q  <= 1'b1;
            pkt_rec_q  <= 1'b0;
            idle_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            pkt_ld_q   <= 1'b0;
            spi_ld_q   <= 1'b0;
            pkt_en_q   <= 1'b0;
            tx_ld_q    <= 1'b0;
            tx_en_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_meta_q  <= cs;
            cs_s_q     <= cs_meta_q;
            cs_prev_q  <= cs_s_q;
            pkt_rec_q  <= pkt_rec;
            idle_cnt_q <= idle_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            pkt_ld_q   <= pkt_ld_d;
            spi_ld_q   <= spi_ld_d;
            pkt_en_q   <= pkt_en_d;
            tx_ld_q    <= tx_ld_d;
            tx_en_q    <= tx_en_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

    assign pkt_ld   = pkt_ld_q;
    assign spi_ld   = spi_ld_q;
    assign pkt_en   = pkt_en_q;
    assign tx_ld    = tx_ld_q;
    assign tx_en    = tx_en_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign byte_cnt = byte_cnt_q;
    assign ovf      = ovf_q;
    assign tmo      = tmo_q;

endmodule

// File: doc/link_seq_ctrl.md
LINK_SEQ_CTRL -- requirements
Module: link_seq_ctrl

Interface
REQ-001 Parameter BYTES, default 8, number of bytes unloaded per received packet (range 1-15).
REQ-002 Parameter BITS, default 8, number of bits shifted per transmitted byte (range 1-15).
REQ-003 Parameter TIMEOUT, default 50000, number of idle clk cycles allowed in an RX unload before it is aborted (16-bit).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 PRESETn  in  1  asynchronous, active-low reset.
REQ-006 rx_mode  in  1  1 = RX (packet unload), 0 = TX (byte transmit); sampled only in IDLE.
REQ-007 pkt_rec  in  1  packet-received level from shift buffer; its rising edge is the event.
REQ-008 cs  in  1  SPI chip select, asynchronous to clk, active-low.
REQ-009 bit_tick  in  1  synchronized one-cycle bit strobe from the shift-enable synchronizer.
REQ-010 ovf_clr  in  1  one-cycle clear of sticky ovf and tmo flags.
REQ-011 pkt_ld  out  1  one-cycle pulse: load 64-bit shift buffer into packet register.
REQ-012 spi_ld  out  1  one-cycle pulse, coincident with pkt_ld: load first byte into SPI slave.
REQ-013 pkt_en  out  1  one-cycle pulse: advance packet register to next byte.
REQ-014 tx_ld  out  1  one-cycle pulse: load SPI output byte into TX buffer.
REQ-015 tx_en  out  1  one-cycle pulse per transmitted bit.
REQ-016 done  out  1  one-cycle pulse at normal completion of an RX unload or TX byte.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 byte_cnt  out  4  number of bytes unloaded in the current/last RX operation.
REQ-019 ovf  out  1  sticky: packet arrived while not in IDLE.
REQ-020 tmo  out  1  sticky: RX unload aborted by timeout.

Function
REQ-021 cs shall pass through a 2-flop synchronizer (cs_s); edges shall be detected against a third registered copy; an edge is acted on in the cycle it is detected.
REQ-022 pkt_rec rising edge shall be detected against its registered value.
REQ-023 All outputs shall be registered; each pulse shall appear exactly one cycle after its triggering condition.
REQ-024 States: IDLE, RX_ARM, RX_XFER, TX_ARM, TX_SHIFT, TX_END.
REQ-025 IDLE, rx_mode=1, pkt_rec rise: pkt_ld=spi_ld=1 for one cycle, byte_cnt<=0, go RX_ARM.
REQ-026 RX_ARM: cs_s falling edge -> RX_XFER.
REQ-027 RX_XFER: cs_s rising edge -> pkt_en pulse, byte_cnt+1; if new byte_cnt==BYTES, done pulse and go IDLE, else go RX_ARM.
REQ-028 Idle counter: cleared on entry to RX_ARM and on any cs_s edge in RX_ARM/RX_XFER; increments otherwise in those states; on reaching TIMEOUT, set tmo, go IDLE, no done pulse, byte_cnt held.
REQ-029 pkt_rec rise in any state other than IDLE: ovf<=1, event otherwise ignored; no pkt_ld.
REQ-030 IDLE, rx_mode=0, cs_s falling edge -> TX_ARM.
REQ-031 TX_ARM: cs_s rising edge -> tx_ld pulse, bit counter<=0, go TX_SHIFT.
REQ-032 TX_SHIFT: each bit_tick -> tx_en pulse, bit counter+1; on the BITS-th tick go TX_END; bit_tick outside TX_SHIFT shall be ignored.
REQ-033 TX_END: done pulse, go IDLE (done one cycle after last tx_en).
REQ-034 rx_mode changes outside IDLE shall have no effect until IDLE is re-entered.
REQ-035 ovf_clr coincident with a set condition: set wins.
REQ-036 At most one of pkt_ld, pkt_en, tx_ld, tx_en shall be high in any cycle.

Reset
REQ-037 PRESETn low shall immediately force state IDLE, all counters 0, all outputs 0, ovf=tmo=0, synchronizer flops to 1 (cs deasserted), pkt_rec history to 0.
REQ-038 Reset mid-operation shall abandon the operation with no done pulse; first event after release is handled from IDLE.

Verification
REQ-039 RX, BYTES=8: pkt_rec rise, then 8 cs low/high frames -> one pkt_ld/spi_ld, 8 pkt_en pulses, byte_cnt=8, one done, busy low after.
REQ-040 RX: pkt_rec rise, 3 cs frames, cs held high TIMEOUT cycles -> tmo=1, byte_cnt=3, no done, IDLE.
REQ-041 RX: second pkt_rec rise during frame 2 -> ovf=1, no second pkt_ld, unload completes with 8 pkt_en; ovf_clr -> ovf=0.
REQ-042 TX, BITS=8: cs low then high -> one tx_ld; 10 bit_ticks -> exactly 8 tx_en, done one cycle after 8th, extra ticks ignored.
REQ-043 rx_mode toggled during TX_SHIFT -> TX completes normally; next pkt_rec rise in IDLE with rx_mode=1 starts RX.
REQ-044 PRESETn asserted in RX_XFER at byte_cnt=5 -> all outputs 0 asynchronously, IDLE, no done.
